// File: rtl/cla_multiword_seq_pkg.sv
// Shared definitions for the multi-word carry-lookahead add sequencer.
package cla_seq_pkg;

  localparam int unsigned LIMB_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;

endpackage

// File: rtl/cla_multiword_seq_cla16.sv
// CLA_16b: 16-bit two-level carry-lookahead adder (4-bit groups), purely combinational.
module CLA_16b (
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic        in2,
  output logic [16:0] out0
);

  always_comb begin
    logic [15:0] g, p, c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;
    g = in0 & in1;
    p = in0 ^ in1;
    for (int unsigned k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Group carries are fully expanded so no carry ripples across groups.
    gc[0] = in2;
    gc[1] = gg[0] | (gp[0] & in2);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & in2);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & in2);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & in2);
    c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int unsigned j = 1; j < 4; j++)
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
    end
    out0 = {gc[4], p ^ c};
  end

endmodule

// File: rtl/cla_multiword_seq.sv
// Adds two WORDS*16-bit operands one limb per cycle through a single shared CLA_16b.
// Optional macro CLA_SEQ_SUB_EN adds the in_sub port for A - B.
module cla_multiword_seq
  import cla_seq_pkg::*;
#(
  parameter  int unsigned WORDS = 4,
  localparam int unsigned CNT_W = $clog2(WORDS > 1 ? WORDS : 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORDS*LIMB_W-1:0]    in_a,
  input  logic [WORDS*LIMB_W-1:0]    in_b,
  input  logic                       in_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                       in_sub,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORDS*LIMB_W:0]      out_sum,
  output logic                       busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  cla_seq_state_t                 state;
  logic [WORDS-1:0][LIMB_W-1:0]   a_q, b_q, sum_q, sum_nx;
  logic                           carry_q;
  logic [CNT_W-1:0]               idx;
  logic [LIMB_W:0]                add;
  logic [WORDS*LIMB_W-1:0]        b_cap;
  logic                           c_cap;
  logic                           accept;

  always_comb begin
`ifdef CLA_SEQ_SUB_EN
    b_cap = in_sub ? ~in_b : in_b;
    c_cap = in_sub | in_cin;
`else
    b_cap = in_b;
    c_cap = in_cin;
`endif
  end

  assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  CLA_16b u_cla (
    .in0  (a_q[idx]),
    .in1  (b_q[idx]),
    .in2  (carry_q),
    .out0 (add)
  );

  always_comb begin
    sum_nx      = sum_q;
    sum_nx[idx] = add[LIMB_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      case (state)
        RUN: begin
          sum_q   <= sum_nx;
          carry_q <= add[LIMB_W];
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_sum   <= {add[LIMB_W], sum_nx};
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          // A DONE handshake and a new accept may coincide; the accept wins and goes straight to RUN.
          if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          if (accept) begin
            a_q     <= in_a;
            b_q     <= b_cap;
            carry_q <= c_cap;
            idx     <= '0;
            state   <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Randomized self-checking bench for cla_multiword_seq against an arithmetic reference model.
module tb_cla_multiword_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = WORDS * 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub_v = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   out_sum;
  logic         busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  cla_multiword_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CLA_SEQ_SUB_EN
    .in_sub    (in_sub_v),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {1'b0, a} - {1'b0, b} + {1'b1, {W{1'b0}}};
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  task automatic rand_word(output logic [W-1:0] v);
    v = {$urandom, $urandom};
  endtask

  // One complete transaction: accept, latency, result, hold under backpressure, drain.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int unsigned hold);
    logic [W:0]  exp;
    int unsigned lat;
    exp = model(a, b, cin, sub);
    in_a = a; in_b = b; in_cin = cin; in_sub_v = sub;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check("accept_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~cin;
    lat = 0;
    while (!out_valid && lat < 50) begin
      check("run_busy", 128'(busy), 128'(1));
      tick();
      lat++;
    end
    check("latency", 128'(lat), 128'(WORDS));
    check("sum", 128'(out_sum), 128'(exp));
    check("done_in_ready", 128'(in_ready), 128'(0));
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_sum", 128'(out_sum), 128'(exp));
      check("hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", 128'(in_ready), 128'(1));
    tick();
    check("drain_valid", 128'(out_valid), 128'(0));
    check("drain_idle", 128'(busy), 128'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb, a2, b2;
    logic [W:0]   e1, e2;
    int unsigned  lat;

    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_sum", 128'(out_sum), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    do_op({W{1'b1}}, 64'd1, 1'b0, 1'b0, 0);
    do_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, 0);
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 5);

    // Back-to-back with in_valid held high
    rand_word(ra); rand_word(rb); rand_word(a2); rand_word(b2);
    e1 = model(ra, rb, 1'b1, 1'b0);
    e2 = model(a2, b2, 1'b0, 1'b0);
    in_a = ra; in_b = rb; in_cin = 1'b1; in_sub_v = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check("b2b_lat1", 128'(lat), 128'(WORDS));
    check("b2b_sum1", 128'(out_sum), 128'(e1));
    in_a = a2; in_b = b2; in_cin = 1'b0;
    #1;
    check("b2b_in_ready", 128'(in_ready), 128'(1));
    tick();
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check("b2b_period", 128'(lat + 1), 128'(WORDS + 1));
    check("b2b_sum2", 128'(out_sum), 128'(e2));
    in_valid = 1'b0;
    tick();
    check("b2b_idle", 128'(busy), 128'(0));
    out_ready = 1'b0;

    // Reset mid-RUN at idx 2
    in_a = {W{1'b1}}; in_b = 64'd3; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("pre_rst_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    check("midrst_valid", 128'(out_valid), 128'(0));
    check("midrst_sum", 128'(out_sum), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    tick();
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    do_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, 0);

`ifdef CLA_SEQ_SUB_EN
    do_op(64'd5, 64'd7, 1'b0, 1'b1, 0);
    do_op(64'd7, 64'd5, 1'b1, 1'b1, 0);
`endif

    for (int n = 0; n < 20; n++) begin
      rand_word(ra); rand_word(rb);
      if (n % 4 == 0) rb = ~ra;
`ifdef CLA_SEQ_SUB_EN
      do_op(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
`else
      do_op(ra, rb, 1'($urandom), 1'b0, $urandom_range(0, 3));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
